// File: rtl/multimac_core_if.sv
// Command/result bundle for multimac_core: master drives commands, slave (the core) returns status/result.
interface multimac_core_if #(
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int ACC_W = 16
);
  localparam int IW = $clog2(DEPTH);

  logic             run;
  logic             load;
  logic [1:0]       insn;
  logic [IW-1:0]    index;
  logic [DW-1:0]    data;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [ACC_W-1:0] out;

  modport master (
    output run, load, insn, index, data,
    input  busy, done, ovf, out
  );

  modport slave (
    input  run, load, insn, index, data,
    output busy, done, ovf, out
  );
endinterface

// File: rtl/multimac_core.sv
// Sequential multiply-accumulate engine over two operand banks (MAC, MACC, SUMSQ, SUM).
// Optional saturation of the accumulator on overflow: define MULTIMAC_SAT_EN.
module multimac_core #(
  parameter int DW    = 4,
  parameter int DEPTH = 16,
  parameter int ACC_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  multimac_core_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    a_q [DEPTH];
  logic [DW-1:0]    a_d [DEPTH];
  logic [DW-1:0]    b_q [DEPTH];
  logic [DW-1:0]    b_d [DEPTH];
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] out_q, out_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    end_q, end_d;
  logic [1:0]       op_q, op_d;
  logic [DW-1:0]    a_sel, b_sel;
  logic [2*DW-1:0]  term;
  logic [ACC_W:0]   sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.run) state_d = RUN;
      RUN:     if (ptr_q == end_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = done_q;
    bus.ovf  = ovf_q;
    bus.out  = out_q;
  end

  always_comb begin
    a_sel = a_q[ptr_q];
    b_sel = b_q[ptr_q];
    unique case (op_q)
      2'b10:   term = (2*DW)'(a_sel) * (2*DW)'(a_sel);
      2'b11:   term = (2*DW)'(a_sel);
      default: term = (2*DW)'(a_sel) * (2*DW)'(b_sel);
    endcase
    sum = (ACC_W+1)'(acc_q) + (ACC_W+1)'(term);
  end

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    out_d  = out_q;
    ovf_d  = ovf_q;
    ptr_d  = ptr_q;
    end_d  = end_q;
    op_d   = op_q;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          end_d = bus.index;
          ptr_d = '0;
          op_d  = bus.insn;
          // MACC continues from the previous accumulator and keeps ovf sticky
          if (bus.insn != 2'b01) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end else if (bus.load) begin
          unique case (bus.insn)
            2'b00: a_d[bus.index] = bus.data;
            2'b01: b_d[bus.index] = bus.data;
            2'b10: begin
              a_d[bus.index] = bus.data;
              b_d[bus.index] = bus.data;
            end
            default: begin
              a_d = '{default: '0};
              b_d = '{default: '0};
            end
          endcase
        end
      end
      RUN: begin
        ptr_d = ptr_q + IW'(1);
        if (sum[ACC_W]) begin
          ovf_d = 1'b1;
`ifdef MULTIMAC_SAT_EN
          acc_d = '1;
`else
          acc_d = sum[ACC_W-1:0];
`endif
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
      end
      DONE: begin
        out_d  = acc_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
      end
      acc_q  <= '0;
      out_q  <= '0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
      ptr_q  <= '0;
      end_q  <= '0;
      op_q   <= '0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      out_q  <= out_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
      ptr_q  <= ptr_d;
      end_q  <= end_d;
      op_q   <= op_d;
    end
  end
endmodule

// File: tb/tb_multimac_core.sv
// Scoreboard bench for multimac_core: a 16-bit and an 8-bit accumulator instance against a reduction model.
`timescale 1ns/1ps
module tb_multimac_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multimac_core_if #(.DW(4), .DEPTH(16), .ACC_W(16)) i0 ();
  multimac_core_if #(.DW(4), .DEPTH(16), .ACC_W(8))  i1 ();

  multimac_core #(.DW(4), .DEPTH(16), .ACC_W(16)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
  multimac_core #(.DW(4), .DEPTH(16), .ACC_W(8))  u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  typedef struct {
    int     out;
    bit     ovf;
    longint due;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;

  int ma [2][16];
  int mb [2][16];
  int macc [2];
  bit movf [2];
  int accw [2] = '{16, 8};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference: reduce entries 0..idx with unbounded integers, folding at the accumulator width
  function automatic void model_run(int s, int op, int idx, output int res, output bit ov);
    longint acc, lim, t;
    lim = longint'(1) << accw[s];
    acc = (op == 1) ? longint'(macc[s]) : 0;
    ov  = (op == 1) ? movf[s] : 1'b0;
    for (int i = 0; i <= idx; i++) begin
      case (op)
        2:       t = ma[s][i] * ma[s][i];
        3:       t = ma[s][i];
        default: t = ma[s][i] * mb[s][i];
      endcase
      acc = acc + t;
      if (acc >= lim) begin
        ov = 1'b1;
`ifdef MULTIMAC_SAT_EN
        acc = lim - 1;
`else
        acc = acc - lim;
`endif
      end
    end
    res = int'(acc);
    macc[s] = res;
    movf[s] = ov;
  endfunction

  function automatic void model_clear(int s);
    for (int i = 0; i < 16; i++) begin
      ma[s][i] = 0;
      mb[s][i] = 0;
    end
  endfunction

  task automatic set_cmd(int s, bit r, bit l, int insn, int idx, int d);
    if (s == 0) begin
      i0.run = r; i0.load = l; i0.insn = insn[1:0]; i0.index = idx[3:0]; i0.data = d[3:0];
    end else begin
      i1.run = r; i1.load = l; i1.insn = insn[1:0]; i1.index = idx[3:0]; i1.data = d[3:0];
    end
  endtask

  function automatic bit busy_of(int s);
    return (s == 0) ? i0.busy : i1.busy;
  endfunction

  task automatic do_load(int s, int insn, int idx, int d);
    @(negedge clk);
    set_cmd(s, 1'b0, 1'b1, insn, idx, d);
    case (insn)
      0: ma[s][idx] = d;
      1: mb[s][idx] = d;
      2: begin ma[s][idx] = d; mb[s][idx] = d; end
      default: model_clear(s);
    endcase
    @(negedge clk);
    set_cmd(s, 1'b0, 1'b0, 0, 0, 0);
  endtask

  // poke: drive load/run/clear while busy; they must have no effect
  task automatic do_run(int s, int op, int idx, bit poke);
    exp_t e;
    int   res;
    bit   ov;
    int   nb;
    @(negedge clk);
    model_run(s, op, idx, res, ov);
    e.out = res;
    e.ovf = ov;
    e.due = cyc + idx + 3;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
    set_cmd(s, 1'b1, 1'b0, op, idx, 0);
    @(negedge clk);
    set_cmd(s, 1'b0, 1'b0, 0, 0, 0);
    nb = 0;
    while (busy_of(s) && nb < 100) begin
      nb++;
      if (poke && nb == 2)      set_cmd(s, 1'b0, 1'b1, 0, 0, 7);
      else if (poke && nb == 3) set_cmd(s, 1'b1, 1'b0, 3, 0, 0);
      else if (poke && nb == 4) set_cmd(s, 1'b0, 1'b1, 3, 0, 0);
      else                      set_cmd(s, 1'b0, 1'b0, 0, 0, 0);
      @(negedge clk);
    end
    set_cmd(s, 1'b0, 1'b0, 0, 0, 0);
    chk($sformatf("u%0d busy cycles idx=%0d", s, idx), nb, idx + 2);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && i0.done) begin
      chk("u0 done with pending expectation", (q0.size() > 0) ? 1 : 0, 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("u0 out", i0.out, e.out);
        chk("u0 ovf", i0.ovf, e.ovf);
        chk("u0 done cycle", cyc, e.due);
      end
    end
    if (rst_n && i1.done) begin
      chk("u1 done with pending expectation", (q1.size() > 0) ? 1 : 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1 out", i1.out, e.out);
        chk("u1 ovf", i1.ovf, e.ovf);
        chk("u1 done cycle", cyc, e.due);
      end
    end
  end

  initial begin
    int s, k, op, idx, ins;
    set_cmd(0, 1'b0, 1'b0, 0, 0, 0);
    set_cmd(1, 1'b0, 1'b0, 0, 0, 0);
    for (int j = 0; j < 2; j++) begin
      model_clear(j);
      macc[j] = 0;
      movf[j] = 1'b0;
    end
    #22;
    chk("reset out", i0.out, 0);
    chk("reset busy", i0.busy, 0);
    chk("reset done", i0.done, 0);
    chk("reset ovf", i0.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      do_load(0, 0, i, i + 1);
      do_load(0, 1, i, 2);
    end
    do_run(0, 0, 3, 1'b0);
    do_run(0, 1, 3, 1'b0);

    for (int i = 0; i < 16; i++) do_load(0, 2, i, 15);
    do_run(0, 0, 15, 1'b0);
    do_run(0, 3, 15, 1'b0);
    do_run(0, 2, 15, 1'b0);

    do_run(0, 0, 7, 1'b1);
    do_run(0, 3, 0, 1'b0);

    do_load(0, 3, 0, 0);
    do_run(0, 0, 15, 1'b0);
    do_load(0, 0, 0, 3);
    do_load(0, 1, 0, 5);
    do_run(0, 0, 0, 1'b0);

    do_load(1, 2, 0, 15);
    do_load(1, 2, 1, 15);
    do_run(1, 0, 1, 1'b0);
    do_run(1, 1, 1, 1'b0);
    do_run(1, 3, 15, 1'b0);

    for (int it = 0; it < 80; it++) begin
      s = $urandom_range(0, 1);
      k = $urandom_range(0, 3);
      if (k < 2) begin
        ins = $urandom_range(0, 3);
        if (ins == 3 && $urandom_range(0, 3) != 0) ins = 2;
        do_load(s, ins, $urandom_range(0, 15), $urandom_range(0, 15));
      end else begin
        op  = $urandom_range(0, 3);
        idx = $urandom_range(0, 15);
        do_run(s, op, idx, (idx >= 3) && ($urandom_range(0, 3) == 0));
      end
    end

    @(negedge clk);
    set_cmd(0, 1'b1, 1'b0, 3, 15, 0);
    @(negedge clk);
    set_cmd(0, 1'b0, 1'b0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("busy before abort", i0.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort out", i0.out, 0);
    chk("abort busy", i0.busy, 0);
    chk("abort done", i0.done, 0);
    chk("abort ovf", i0.ovf, 0);
    for (int j = 0; j < 2; j++) begin
      model_clear(j);
      macc[j] = 0;
      movf[j] = 1'b0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_run(0, 3, 15, 1'b0);

    repeat (5) @(negedge clk);
    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
